// File: rtl/framebuffer_db_if.sv
// rtl/framebuffer_db_if.sv - pixel-write and commit handshake between frame producer and framebuffer
interface framebuffer_db_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_led;
  logic [23:0] wr_rgb;
  logic        commit;

  modport master (
    output wr_valid,
    output wr_led,
    output wr_rgb,
    output commit,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_led,
    input  wr_rgb,
    input  commit,
    output wr_ready
  );
endinterface

// File: rtl/framebuffer_db.sv
// rtl/framebuffer_db.sv - double-buffered LED frame store feeding a neopixel driver
module framebuffer_db #(
  parameter int NUM_LEDS = 16
) (
  input  logic            clk_20M,
  input  logic            nrst,
  framebuffer_db_if.slave wr,
  input  logic [8:0]      r_addr,
  output logic [7:0]      dout,
  output logic            swap_done,
  output logic            front_sel
);

  localparam int BANK = 4 * NUM_LEDS;
  localparam int AW   = $clog2(2 * BANK);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, SWAP_WAIT, COPY} state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic [3:0]    led_q;
  logic [23:0]   rgb_q;
  logic          commit_pending_q;
  logic          wr_ready_q;
  logic          swap_done_q;
  logic          front_sel_q;
  logic [7:0]    dout_q;

  // Both banks live in one array: bank 0 at [0, BANK), bank 1 at [BANK, 2*BANK).
  logic [7:0]    mem [2*BANK];

  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [7:0]    mem_wdata_d;
  logic          led_ok;
  logic          rd_hit;

  function automatic logic [AW-1:0] bank_idx(input logic bank, input logic [AW-1:0] b);
    return bank ? (b + AW'(BANK)) : b;
  endfunction

  assign led_ok       = ({28'd0, wr.wr_led} < 32'(NUM_LEDS));
  assign rd_hit       = (r_addr < 9'(BANK));
  assign wr.wr_ready  = wr_ready_q;
  assign dout         = dout_q;
  assign swap_done    = swap_done_q;
  assign front_sel    = front_sel_q;

  // Single memory write port: CLEAR zeroes everything, WRITE/COPY only touch the back bank.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = 8'h00;
    case (state_q)
      CLEAR: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = cnt_q;
      end
      WRITE: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = bank_idx(!front_sel_q, AW'({led_q, cnt_q[1:0]}));
        case (cnt_q[1:0])
          2'd0:    mem_wdata_d = rgb_q[15:8];
          2'd1:    mem_wdata_d = rgb_q[23:16];
          2'd2:    mem_wdata_d = rgb_q[7:0];
          default: mem_wdata_d = 8'h00;
        endcase
      end
      COPY: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = bank_idx(!front_sel_q, cnt_q);
        mem_wdata_d = mem[bank_idx(front_sel_q, cnt_q)];
      end
      default: ;
    endcase
    if (!nrst) mem_we_d = 1'b0;
  end

  // Frame storage update.
  always_ff @(posedge clk_20M) begin
    if (mem_we_d) mem[mem_waddr_d] <= mem_wdata_d;
  end

  // Driver read path: front bank only, one-cycle latency, zero outside the bank.
  always_ff @(posedge clk_20M) begin
    if (!nrst)       dout_q <= 8'h00;
    else if (rd_hit) dout_q <= mem[bank_idx(front_sel_q, AW'(r_addr))];
    else             dout_q <= 8'h00;
  end

  // Control FSM: clear, pixel writes, commit tracking, swap on r_addr==0, then bank copy.
  always_ff @(posedge clk_20M) begin
    if (!nrst) begin
      state_q          <= CLEAR;
      cnt_q            <= '0;
      led_q            <= '0;
      rgb_q            <= '0;
      commit_pending_q <= 1'b0;
      wr_ready_q       <= 1'b0;
      swap_done_q      <= 1'b0;
      front_sel_q      <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          if (cnt_q == AW'(2 * BANK - 1)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        IDLE: begin
          if (commit_pending_q) begin
            state_q    <= SWAP_WAIT;
            wr_ready_q <= 1'b0;
          end else begin
            if (wr.commit) commit_pending_q <= 1'b1;
            if (wr.wr_valid && wr_ready_q) begin
              // Out-of-range LEDs are accepted but dropped: ready dips for one cycle.
              led_q      <= wr.wr_led;
              rgb_q      <= wr.wr_rgb;
              cnt_q      <= '0;
              wr_ready_q <= 1'b0;
              if (led_ok) state_q <= WRITE;
            end else begin
              wr_ready_q <= !wr.commit;
            end
          end
        end
        WRITE: begin
          if (wr.commit) commit_pending_q <= 1'b1;
          if (cnt_q[1:0] == 2'd3) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ready_q <= !(commit_pending_q || wr.commit);
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        SWAP_WAIT: begin
          if (r_addr == 9'd0) begin
            front_sel_q      <= !front_sel_q;
            swap_done_q      <= 1'b1;
            commit_pending_q <= 1'b0;
            cnt_q            <= '0;
            state_q          <= COPY;
          end
        end
        COPY: begin
          if (cnt_q == AW'(BANK - 1)) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q    <= CLEAR;
          cnt_q      <= '0;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_db.sv
// tb/tb_framebuffer_db.sv - directed self-checking bench for framebuffer_db
module tb_framebuffer_db;
  logic       clk_20M = 1'b0;
  always #25 clk_20M = ~clk_20M;

  logic       nrst;
  logic [8:0] r_addr, r_addr8;
  logic [7:0] dout, dout8;
  logic       swap_done, swap_done8, front_sel, front_sel8;
  int         total = 0;
  int         bad = 0;

  framebuffer_db_if bus();
  framebuffer_db_if bus8();

  framebuffer_db u_dut (
    .clk_20M(clk_20M), .nrst(nrst), .wr(bus), .r_addr(r_addr),
    .dout(dout), .swap_done(swap_done), .front_sel(front_sel)
  );

  framebuffer_db #(.NUM_LEDS(8)) u_dut8 (
    .clk_20M(clk_20M), .nrst(nrst), .wr(bus8), .r_addr(r_addr8),
    .dout(dout8), .swap_done(swap_done8), .front_sel(front_sel8)
  );

  task automatic tick();
    @(posedge clk_20M);
    #1;
  endtask

  task automatic rd16(input logic [8:0] a, output logic [7:0] d);
    r_addr = a;
    tick();
    d = dout;
  endtask

  task automatic rd8(input logic [8:0] a, output logic [7:0] d);
    r_addr8 = a;
    tick();
    d = dout8;
  endtask

  task automatic wait_ready16(input string tag);
    int n = 0;
    while (bus.wr_ready !== 1'b1 && n < 400) begin tick(); n++; end
    if (n >= 400) begin total++; bad++; $display("FAIL %s: wr_ready never rose", tag); end
  endtask

  task automatic wait_ready8(input string tag);
    int n = 0;
    while (bus8.wr_ready !== 1'b1 && n < 400) begin tick(); n++; end
    if (n >= 400) begin total++; bad++; $display("FAIL %s: wr_ready8 never rose", tag); end
  endtask

  task automatic write16(input logic [3:0] led, input logic [23:0] rgb);
    wait_ready16("write16");
    bus.wr_led = led; bus.wr_rgb = rgb; bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.wr_led = 4'hx; bus.wr_rgb = 24'hx;
  endtask

  task automatic write8(input logic [3:0] led, input logic [23:0] rgb);
    wait_ready8("write8");
    bus8.wr_led = led; bus8.wr_rgb = rgb; bus8.wr_valid = 1'b1;
    tick();
    bus8.wr_valid = 1'b0; bus8.wr_led = 4'h0; bus8.wr_rgb = 24'h0;
  endtask

  task automatic wait_swap16(input string tag);
    int n = -1;
    r_addr = 9'd0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (swap_done === 1'b1) begin n = i; break; end
    end
    total++;
    if (n < 0) begin bad++; $display("FAIL %s: swap_done timeout", tag); end
  endtask

  task automatic check_clear_after_reset(input string tag);
    int n = -1, swaps = 0;
    logic [7:0] d;
    r_addr = 9'd0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (swap_done === 1'b1) swaps++;
      if (bus.wr_ready === 1'b1 && n < 0) n = i;
    end
    total++;
    if (n != 128) begin bad++; $display("FAIL %s_ready_cycle got=%0d exp=128", tag, n); end
    total++;
    if (swaps != 0) begin bad++; $display("FAIL %s_swaps got=%0d exp=0", tag, swaps); end
    total++;
    if (front_sel !== 1'b0) begin bad++; $display("FAIL %s_front_sel got=%b exp=0", tag, front_sel); end
    for (int i = 0; i < 64; i++) begin
      rd16(9'(i), d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL %s_read addr=%0d got=%h exp=00", tag, i, d); end
    end
  endtask

  task automatic test_reset();
    int n16 = -1, n8 = -1;
    logic [7:0] d;
    nrst = 1'b0;
    tick();
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b exp=0", bus.wr_ready); end
    total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL rst_front_sel got=%b exp=0", front_sel); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", dout); end
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL rst_swap_done got=%b exp=0", swap_done); end
    nrst = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.wr_ready === 1'b1 && n16 < 0) n16 = i;
      if (bus8.wr_ready === 1'b1 && n8 < 0) n8 = i;
      if (n16 > 0 && n8 > 0) break;
    end
    total++; if (n16 != 128) begin bad++; $display("FAIL clear_cycles got=%0d exp=128", n16); end
    total++; if (n8 != 64) begin bad++; $display("FAIL clear_cycles8 got=%0d exp=64", n8); end
    total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL post_clear_front got=%b exp=0", front_sel); end
    for (int i = 0; i < 64; i++) begin
      rd16(9'(i), d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL clear_read addr=%0d got=%h exp=00", i, d); end
    end
    rd16(9'd511, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL oob_read got=%h exp=00", d); end
  endtask

  task automatic test_swap();
    int swaps = 0;
    logic [7:0] d;
    logic [7:0] exp [6] = '{8'h00, 8'h22, 8'h11, 8'h33, 8'h00, 8'h00};
    r_addr = 9'd5;
    write16(4'd2, 24'h112233);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (swap_done === 1'b1) swaps++;
    end
    total++; if (swaps != 0) begin bad++; $display("FAIL swap_held_addr5 got=%0d exp=0", swaps); end
    total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL front_before_swap got=%b exp=0", front_sel); end
    r_addr = 9'd0;
    tick();
    total++; if (swap_done !== 1'b1) begin bad++; $display("FAIL swap_pulse got=%b exp=1", swap_done); end
    total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL front_after_swap got=%b exp=1", front_sel); end
    tick();
    total++; if (swap_done !== 1'b0) begin bad++; $display("FAIL swap_pulse_width got=%b exp=0", swap_done); end
    for (int i = 0; i < 6; i++) begin
      rd16(9'(7 + i), d);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL led2_read addr=%0d got=%h exp=%h", 7 + i, d, exp[i]); end
    end
  endtask

  task automatic test_copy_incremental();
    logic [7:0] d;
    logic [7:0] exp [8] = '{8'h22, 8'h11, 8'h33, 8'h00, 8'hBB, 8'hAA, 8'hCC, 8'h00};
    write16(4'd3, 24'hAABBCC);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    wait_swap16("copy_swap");
    total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL copy_front got=%b exp=0", front_sel); end
    for (int i = 0; i < 8; i++) begin
      rd16(9'(8 + i), d);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL copy_read addr=%0d got=%h exp=%h", 8 + i, d, exp[i]); end
    end
  endtask

  task automatic test_commit_with_write();
    int n = -1;
    logic [7:0] d;
    logic [7:0] exp [8] = '{8'hBB, 8'hAA, 8'hCC, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00};
    wait_ready16("cw_ready");
    r_addr = 9'd0;
    bus.wr_led = 4'd15; bus.wr_rgb = 24'h010203; bus.wr_valid = 1'b1; bus.commit = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.commit = 1'b0; bus.wr_led = 4'd0; bus.wr_rgb = 24'hFFFFFF;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (swap_done === 1'b1) begin n = i; break; end
    end
    total++; if (n != 6) begin bad++; $display("FAIL cw_swap_latency got=%0d exp=6", n); end
    total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL cw_front got=%b exp=1", front_sel); end
    for (int i = 0; i < 8; i++) begin
      logic [8:0] a;
      a = (i < 4) ? 9'(12 + i) : 9'(56 + i);
      rd16(a, d);
      total++;
      if (d !== exp[i]) begin bad++; $display("FAIL cw_read addr=%0d got=%h exp=%h", a, d, exp[i]); end
    end
  endtask

  task automatic test_commit_ignored();
    int swaps = 0;
    r_addr = 9'd0;
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (swap_done === 1'b1) swaps++;
    end
    total++; if (swaps != 0) begin bad++; $display("FAIL commit_in_copy swaps got=%0d exp=0", swaps); end
    total++; if (front_sel !== 1'b1) begin bad++; $display("FAIL commit_in_copy front got=%b exp=1", front_sel); end
    wait_ready16("ci_ready");
    r_addr = 9'd5;
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    r_addr = 9'd0;
    swaps = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (swap_done === 1'b1) swaps++;
    end
    total++; if (swaps != 1) begin bad++; $display("FAIL commit_in_swap_wait swaps got=%0d exp=1", swaps); end
    total++; if (front_sel !== 1'b0) begin bad++; $display("FAIL commit_in_swap_wait front got=%b exp=0", front_sel); end
  endtask

  task automatic test_out_of_range();
    int n = -1;
    logic [7:0] d, e;
    r_addr8 = 9'd0;
    write8(4'd7, 24'h445566);
    for (int i = 1; i <= 20; i++) begin
      if (bus8.wr_ready === 1'b1) begin n = i; break; end
      tick();
    end
    total++; if (n != 5) begin bad++; $display("FAIL write_ready_gap got=%0d exp=5", n); end
    write8(4'd8, 24'h778899);
    total++; if (bus8.wr_ready !== 1'b0) begin bad++; $display("FAIL discard_ready_low got=%b exp=0", bus8.wr_ready); end
    tick();
    total++; if (bus8.wr_ready !== 1'b1) begin bad++; $display("FAIL discard_ready_back got=%b exp=1", bus8.wr_ready); end
    bus8.commit = 1'b1; tick(); bus8.commit = 1'b0;
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (swap_done8 === 1'b1) begin n = i; break; end
    end
    total++; if (n < 0) begin bad++; $display("FAIL discard_swap timeout got=%0d exp=>0", n); end
    total++; if (front_sel8 !== 1'b1) begin bad++; $display("FAIL discard_front got=%b exp=1", front_sel8); end
    for (int i = 0; i < 33; i++) begin
      case (i)
        28: e = 8'h55;
        29: e = 8'h44;
        30: e = 8'h66;
        default: e = 8'h00;
      endcase
      rd8(9'(i), d);
      total++;
      if (d !== e) begin bad++; $display("FAIL discard_read addr=%0d got=%h exp=%h", i, d, e); end
    end
  endtask

  task automatic test_reset_abort();
    wait_ready16("ra_ready");
    r_addr = 9'd0;
    write16(4'd4, 24'hFFFFFF);
    tick();
    nrst = 1'b0; tick(); nrst = 1'b1;
    check_clear_after_reset("abort_write");
    write16(4'd1, 24'h123456);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    wait_swap16("abort_copy_swap");
    for (int i = 0; i < 3; i++) tick();
    nrst = 1'b0; tick(); nrst = 1'b1;
    check_clear_after_reset("abort_copy");
  endtask

  initial begin
    nrst = 1'b0;
    r_addr = 9'd0; r_addr8 = 9'd0;
    bus.wr_valid = 1'b0; bus.wr_led = 4'd0; bus.wr_rgb = 24'd0; bus.commit = 1'b0;
    bus8.wr_valid = 1'b0; bus8.wr_led = 4'd0; bus8.wr_rgb = 24'd0; bus8.commit = 1'b0;
    tick(); tick();
    test_reset();
    test_swap();
    test_copy_incremental();
    test_commit_with_write();
    test_commit_ignored();
    test_out_of_range();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
